// File: rtl/platform_sched.sv
// platform_sched: game-flow FSM and seven-platform scroll/respawn scheduler.
// Owns the platform layout, score and terminated flag, and issues a one-cycle
// doodle physics reset whenever a finished game is restarted.
module platform_sched #(
   parameter int unsigned SPACING = 70,
   parameter int unsigned TOP     = 10,
   parameter int unsigned BOTTOM  = 470,
   parameter int unsigned HMAX    = 565,
   parameter logic [9:0]  SEED    = 10'h2A5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        tick,
   input  logic [9:0]  d_y,
   output logic [9:0]  p1_vpos,
   output logic [9:0]  p2_vpos,
   output logic [9:0]  p3_vpos,
   output logic [9:0]  p4_vpos,
   output logic [9:0]  p5_vpos,
   output logic [9:0]  p6_vpos,
   output logic [9:0]  p7_vpos,
   output logic [9:0]  p1_hpos,
   output logic [9:0]  p2_hpos,
   output logic [9:0]  p3_hpos,
   output logic [9:0]  p4_hpos,
   output logic [9:0]  p5_hpos,
   output logic [9:0]  p6_hpos,
   output logic [9:0]  p7_hpos,
   output logic        terminated,
   output logic        doodle_rst,
   output logic [13:0] score,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam int unsigned NPLAT     = 7;
   localparam logic [9:0]  WRAP_V    = 10'(NPLAT * SPACING - 1);
   localparam logic [9:0]  TOP_V     = 10'(TOP);
   localparam logic [9:0]  BOTTOM_V  = 10'(BOTTOM);
   localparam logic [9:0]  HMAX_V    = 10'(HMAX);
   localparam logic [13:0] SCORE_MAX = 14'd9999;

   state_t      state_q;
   logic [9:0]  vpos_q [NPLAT];
   logic [9:0]  hpos_q [NPLAT];
   logic [9:0]  lfsr_q;
   logic [9:0]  respawn_h;
   logic [2:0]  wrap_cnt;
   logic [14:0] score_sum;
   logic [13:0] score_next;
   logic        lose;

   function automatic logic [9:0] init_vpos(input int unsigned i);
      return 10'(40 + SPACING * i);
   endfunction

   function automatic logic [9:0] init_hpos(input int unsigned i);
      case (i)
         0:       return 10'd100;
         1:       return 10'd300;
         2:       return 10'd50;
         3:       return 10'd250;
         4:       return 10'd400;
         5:       return 10'd150;
         default: return 10'd350;
      endcase
   endfunction

   // Respawn position, wrap count and saturated next score for this tick.
   always_comb begin
      respawn_h = (lfsr_q >= HMAX_V) ? (lfsr_q - HMAX_V) : lfsr_q;
      wrap_cnt  = '0;
      for (int unsigned i = 0; i < NPLAT; i++) begin
         if (vpos_q[i] == '0) wrap_cnt = wrap_cnt + 3'd1;
      end
      score_sum  = {1'b0, score} + {12'd0, wrap_cnt};
      score_next = (score_sum >= {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
      lose       = (d_y <= TOP_V) || (d_y >= BOTTOM_V);
   end

   // Game FSM, platform scroll/respawn, score and LFSR state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NPLAT; i++) begin
            vpos_q[i] <= init_vpos(i);
            hpos_q[i] <= init_hpos(i);
         end
         state_q    <= S_IDLE;
         terminated <= 1'b0;
         doodle_rst <= 1'b0;
         score      <= '0;
         lfsr_q     <= SEED;
      end else begin
         lfsr_q     <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
         doodle_rst <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) state_q <= S_PLAY;
            end
            S_PLAY: begin
               // Losing wins over a coincident tick: nothing scrolls that cycle.
               if (lose) begin
                  state_q    <= S_OVER;
                  terminated <= 1'b1;
               end else if (tick) begin
                  for (int unsigned i = 0; i < NPLAT; i++) begin
                     if (vpos_q[i] == '0) begin
                        vpos_q[i] <= WRAP_V;
                        hpos_q[i] <= respawn_h;
                     end else begin
                        vpos_q[i] <= vpos_q[i] - 10'd1;
                     end
                  end
                  score <= score_next;
               end
            end
            S_OVER: begin
               if (start) begin
                  for (int unsigned i = 0; i < NPLAT; i++) begin
                     vpos_q[i] <= init_vpos(i);
                     hpos_q[i] <= init_hpos(i);
                  end
                  state_q    <= S_IDLE;
                  terminated <= 1'b0;
                  score      <= '0;
                  doodle_rst <= 1'b1;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               terminated <= 1'b0;
            end
         endcase
      end
   end

   assign state   = state_q;
   assign p1_vpos = vpos_q[0];
   assign p2_vpos = vpos_q[1];
   assign p3_vpos = vpos_q[2];
   assign p4_vpos = vpos_q[3];
   assign p5_vpos = vpos_q[4];
   assign p6_vpos = vpos_q[5];
   assign p7_vpos = vpos_q[6];
   assign p1_hpos = hpos_q[0];
   assign p2_hpos = hpos_q[1];
   assign p3_hpos = hpos_q[2];
   assign p4_hpos = hpos_q[3];
   assign p5_hpos = hpos_q[4];
   assign p6_hpos = hpos_q[5];
   assign p7_hpos = hpos_q[6];

endmodule
